// File: rtl/types_pkg.sv
// types_pkg: shared state encoding for the keystream arbiter
package types_pkg;
    typedef enum logic [2:0] {
        A_IDLE    = 3'd0,
        A_ISSUE   = 3'd1,
        A_WAIT    = 3'd2,
        A_DELIVER = 3'd3,
        A_REKEY   = 3'd4
    } keystream_arb_state_t;
endpackage

// File: rtl/round_robin_arbiter2.sv
// round_robin_arbiter2: two-way winner, the requester not granted last wins a tie
module round_robin_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] win
);
    assign win = &req ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/keystream_arbiter.sv
// keystream_arbiter: shares one keystream generator between encrypt and decrypt channels
module keystream_arbiter
    import types_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [1:0]           req_i,
    input  logic                 key_update_i,
    output logic [7:0]           byte_o,
    output logic [1:0]           byte_valid_o,
    output logic [1:0]           grant_o,
    output logic                 request_hash_byte_pulse_o,
    output logic                 reset_hash_o,
    input  logic [7:0]           hash_byte_i,
    input  logic                 hash_byte_pulse_i,
    output logic                 timeout_err_o,
    output logic [CNT_WIDTH-1:0] byte_count_o,
    output logic                 busy_o
);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

    keystream_arb_state_t state, next;
    logic [TW-1:0] timer, timer_n;
    logic [1:0]    grant_n, win;
    logic [7:0]    byte_n;
    logic          pend, pend_n, err_n, last, last_n;

    round_robin_arbiter2 u_arb (.req(req_i), .last(last), .win(win));

    // next state plus the next value of every register; outputs are derived from next
    always_comb begin
        next    = state;
        timer_n = timer;
        grant_n = grant_o;
        byte_n  = byte_o;
        pend_n  = pend | key_update_i;
        err_n   = timeout_err_o;
        last_n  = last;
        unique case (state)
            A_IDLE: begin
                if (pend) next = A_REKEY;
                else if (|req_i) begin
                    next    = A_ISSUE;
                    grant_n = win;
                end
            end
            A_ISSUE: begin
                timer_n = '0;
                next    = A_WAIT;
            end
            A_WAIT: begin
                if (hash_byte_pulse_i) begin
                    byte_n = hash_byte_i;
                    next   = A_DELIVER;
                end else if (timer == TO_MAX) begin
                    err_n   = 1'b1;
                    pend_n  = 1'b1;
                    grant_n = 2'b00;
                    next    = A_IDLE;
                end else timer_n = timer + 1'b1;
            end
            A_DELIVER: begin
                last_n  = grant_o[1];
                grant_n = 2'b00;
                next    = A_IDLE;
            end
            A_REKEY: begin
                pend_n = key_update_i;
                next   = A_IDLE;
            end
            default: next = A_IDLE;
        endcase
    end

    // state and registered outputs; strobes are decoded from the state being entered
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state                     <= A_IDLE;
            timer                     <= '0;
            grant_o                   <= 2'b00;
            byte_o                    <= 8'h00;
            byte_valid_o              <= 2'b00;
            request_hash_byte_pulse_o <= 1'b0;
            reset_hash_o              <= 1'b0;
            timeout_err_o             <= 1'b0;
            byte_count_o              <= '0;
            busy_o                    <= 1'b0;
            pend                      <= 1'b0;
            last                      <= 1'b1;
        end else begin
            state                     <= next;
            timer                     <= timer_n;
            grant_o                   <= grant_n;
            byte_o                    <= byte_n;
            byte_valid_o              <= (next == A_DELIVER) ? grant_n : 2'b00;
            request_hash_byte_pulse_o <= next == A_ISSUE;
            reset_hash_o              <= next == A_REKEY;
            timeout_err_o             <= err_n;
            byte_count_o              <= byte_count_o + CNT_WIDTH'(next == A_DELIVER);
            busy_o                    <= next != A_IDLE;
            pend                      <= pend_n;
            last                      <= last_n;
        end
    end
endmodule

// File: tb/tb_keystream_arbiter.sv
// tb_keystream_arbiter: directed checks of arbitration, rekey, timeout, reset and counter wrap
module tb_keystream_arbiter;
    logic       clk = 1'b0;
    logic       nrst = 1'b1;
    logic [1:0] req = 2'b00;
    logic       key_update = 1'b0;
    logic [7:0] hash_byte = 8'h00;
    logic       hash_pulse = 1'b0;
    logic [7:0] byte_out;
    logic [1:0] byte_valid, grant;
    logic       rq_pulse, rst_hash, err, busy;
    logic [3:0] count;
    int         checks = 0;
    int         errors = 0;

    keystream_arbiter #(.TIMEOUT_CYCLES(8), .CNT_WIDTH(4)) dut (
        .clk(clk), .nrst(nrst), .req_i(req), .key_update_i(key_update),
        .byte_o(byte_out), .byte_valid_o(byte_valid), .grant_o(grant),
        .request_hash_byte_pulse_o(rq_pulse), .reset_hash_o(rst_hash),
        .hash_byte_i(hash_byte), .hash_byte_pulse_i(hash_pulse),
        .timeout_err_o(err), .byte_count_o(count), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        req = 2'b00; key_update = 1'b0; hash_pulse = 1'b0;
        nrst = 1'b0;
        step();
        step();
        nrst = 1'b1;
    endtask

    // one transaction from an IDLE cycle with req already driven; generator answers in WAIT cycle lat
    task automatic transact(input logic [1:0] g, input logic [7:0] d, input int lat);
        step();
        check("issue_grant", 32'(grant), 32'(g));
        check("issue_pulse", 32'(rq_pulse), 1);
        repeat (lat) step();
        check("wait_quiet", 32'(byte_valid), 0);
        hash_byte = d; hash_pulse = 1'b1;
        step();
        hash_pulse = 1'b0;
        check("deliver_valid", 32'(byte_valid), 32'(g));
        check("deliver_byte", 32'(byte_out), 32'(d));
        step();
        check("idle_valid", 32'(byte_valid), 0);
        check("idle_busy", 32'(busy), 0);
    endtask

    initial begin
        nrst = 1'b0;
        step();
        check("rst_byte", 32'(byte_out), 0);
        check("rst_valid", 32'(byte_valid), 0);
        check("rst_grant", 32'(grant), 0);
        check("rst_rqpulse", 32'(rq_pulse), 0);
        check("rst_hashrst", 32'(rst_hash), 0);
        check("rst_err", 32'(err), 0);
        check("rst_count", 32'(count), 0);
        check("rst_busy", 32'(busy), 0);
        reset_dut();

        req = 2'b01;
        transact(2'b01, 8'hA5, 3);
        req = 2'b00;
        check("single_count", 32'(count), 1);
        step();
        check("single_once", 32'(byte_valid), 0);
        check("single_idle", 32'(busy), 0);

        reset_dut();
        req = 2'b11;
        transact(2'b01, 8'h11, 1);
        transact(2'b10, 8'h22, 2);
        transact(2'b01, 8'h33, 1);
        transact(2'b10, 8'h44, 1);
        req = 2'b00;
        check("rr_count", 32'(count), 4);

        reset_dut();
        req = 2'b01;
        step();
        step();
        key_update = 1'b1;
        step();
        step();
        key_update = 1'b0;
        hash_byte = 8'h3C; hash_pulse = 1'b1;
        step();
        hash_pulse = 1'b0;
        check("rekey_valid", 32'(byte_valid), 1);
        check("rekey_byte", 32'(byte_out), 32'h3C);
        check("rekey_no_early", 32'(rst_hash), 0);
        step();
        check("rekey_idle_hr", 32'(rst_hash), 0);
        check("rekey_idle_rq", 32'(rq_pulse), 0);
        step();
        check("rekey_pulse", 32'(rst_hash), 1);
        check("rekey_rq_blocked", 32'(rq_pulse), 0);
        check("rekey_busy", 32'(busy), 1);
        step();
        check("rekey_once", 32'(rst_hash), 0);
        step();
        check("rekey_reissue", 32'(rq_pulse), 1);
        check("rekey_merged", 32'(rst_hash), 0);

        reset_dut();
        req = 2'b01;
        step();
        check("to_issue", 32'(rq_pulse), 1);
        repeat (8) step();
        check("to_wait8_err", 32'(err), 0);
        check("to_wait8_busy", 32'(busy), 1);
        step();
        check("to_err", 32'(err), 1);
        check("to_grant_clr", 32'(grant), 0);
        check("to_no_valid", 32'(byte_valid), 0);
        step();
        check("to_hashrst", 32'(rst_hash), 1);
        step();
        check("to_hashrst_once", 32'(rst_hash), 0);
        transact(2'b01, 8'h77, 1);
        req = 2'b00;
        check("to_count", 32'(count), 1);
        check("to_sticky", 32'(err), 1);

        reset_dut();
        req = 2'b01;
        step();
        step();
        check("mid_in_wait", 32'(busy), 1);
        nrst = 1'b0;
        #1;
        check("mid_grant", 32'(grant), 0);
        check("mid_busy", 32'(busy), 0);
        check("mid_rq", 32'(rq_pulse), 0);
        step();
        nrst = 1'b1; req = 2'b00;
        hash_byte = 8'hEE; hash_pulse = 1'b1;
        step();
        hash_pulse = 1'b0;
        check("late_valid", 32'(byte_valid), 0);
        step();
        check("late_valid2", 32'(byte_valid), 0);
        check("late_count", 32'(count), 0);

        reset_dut();
        req = 2'b01;
        for (int i = 0; i < 16; i++) transact(2'b01, 8'(i + 8'h40), 1);
        check("wrap_16", 32'(count), 0);
        transact(2'b01, 8'h5A, 2);
        req = 2'b00;
        check("wrap_17", 32'(count), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
